// File: rtl/priority_encoder8x3_hs_if.sv
// priority_encoder8x3_hs_if
//   Bundles the request lines, the code valid/ready handshake and the status
//   outputs of the sequential 8-to-3 priority encoder.
//   slave  : the encoder side (samples req/code_ready, drives the rest)
//   master : the event-source / consumer side
interface priority_encoder8x3_hs_if;
  logic [7:0] req;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] pending;
  logic       overflow;

  modport slave (
    input  req,
    input  code_ready,
    output code,
    output code_valid,
    output pending,
    output overflow
  );

  modport master (
    output req,
    output code_ready,
    input  code,
    input  code_valid,
    input  pending,
    input  overflow
  );
endinterface

// File: rtl/priority_encoder8x3_hs.sv
// priority_encoder8x3_hs
//   Captures rising edges on 8 request lines into a pending register and
//   delivers one pending index at a time as a 3-bit code over valid/ready.
//   ROUND_ROBIN = 0 : highest pending index wins
//   ROUND_ROBIN = 1 : search starts one past the last issued code, wrapping
// Ports
//   i_clk    : clock, all state on the rising edge
//   i_rst_n  : synchronous active-low reset
//   bus      : req, code_ready in; code, code_valid, pending, overflow out
//
// state     | meaning
// S_IDLE    | nothing presented, code_valid = 0
// S_PRESENT | code holds a valid index awaiting code_ready
module priority_encoder8x3_hs #(
  parameter int ROUND_ROBIN = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  priority_encoder8x3_hs_if.slave        bus
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_req_q;
  logic [7:0] r_pending;
  logic [2:0] r_code;
  logic [2:0] r_last;
  logic       r_overflow;

  logic [7:0]  w_rise;
  logic [7:0]  w_clr;
  logic        w_load;
  logic        w_any;
  logic [2:0]  w_sel;
  logic [2:0]  w_sel_fix;
  logic [2:0]  w_sel_rr;
  logic [2:0]  w_start;
  logic [15:0] w_dbl;
  logic [15:0] w_shift;
  logic [7:0]  w_rot;
  logic [2:0]  w_off;

  assign w_rise = bus.req & ~r_req_q;
  assign w_any  = |r_pending;

  // Fixed priority: later loop iterations overwrite, so the highest index wins.
  always_comb begin
    w_sel_fix = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_pending[i]) w_sel_fix = 3'(i);
    end
  end

  // Round robin: rotate pending so index last+1 lands at bit 0, pick the
  // lowest set bit, then rotate the offset back (3-bit add wraps mod 8).
  assign w_start = r_last + 3'd1;
  assign w_dbl   = {r_pending, r_pending};
  assign w_shift = w_dbl >> w_start;
  assign w_rot   = w_shift[7:0];

  always_comb begin
    w_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) w_off = 3'(i);
    end
  end

  assign w_sel_rr = w_start + w_off;
  assign w_sel    = (ROUND_ROBIN != 0) ? w_sel_rr : w_sel_fix;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (bus.code_ready) begin
          if (w_any) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_clr = w_load ? (8'b1 << w_sel) : 8'h00;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_req_q    <= 8'h00;
      r_pending  <= 8'h00;
      r_code     <= 3'd0;
      r_last     <= 3'd7;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_q    <= bus.req;
      // Set wins over clear: a new event on the bit being loaded re-arms it.
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      r_overflow <= |(w_rise & r_pending & ~w_clr);
      if (w_load) begin
        r_code <= w_sel;
        r_last <= w_sel;
      end
    end
  end

  assign bus.code       = r_code;
  assign bus.code_valid = (r_state == S_PRESENT);
  assign bus.pending    = r_pending;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_priority_encoder8x3_hs.sv
// Drives a fixed-priority and a round-robin encoder with identical stimulus
// and compares both against an untimed per-edge reference model.
module tb_priority_encoder8x3_hs;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  priority_encoder8x3_hs_if u_if_fp ();
  priority_encoder8x3_hs_if u_if_rr ();

  priority_encoder8x3_hs #(.ROUND_ROBIN(0)) u_dut_fp (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if_fp)
  );

  priority_encoder8x3_hs #(.ROUND_ROBIN(1)) u_dut_rr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_if_rr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] req;
  logic       ready;

  always_comb begin
    u_if_fp.req        = req;
    u_if_rr.req        = req;
    u_if_fp.code_ready = ready;
    u_if_rr.code_ready = ready;
  end

  // reference model state, index 0 = fixed priority, 1 = round robin
  logic [7:0] m_pend  [2];
  logic [7:0] m_reqq  [2];
  logic [2:0] m_last  [2];
  logic [2:0] m_code  [2];
  logic       m_valid [2];
  logic       m_ovf   [2];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] pick(input logic [7:0] p, input logic [2:0] last, input int rr);
    int idx;
    if (rr != 0) begin
      for (int k = 1; k <= 8; k++) begin
        idx = (int'(last) + k) % 8;
        if (p[idx]) return 3'(idx);
      end
    end else begin
      for (int i = 7; i >= 0; i--) if (p[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic model_step(input int m);
    logic [7:0] rise;
    logic [7:0] clr;
    logic [2:0] s;
    if (!rst_n) begin
      m_pend[m] = 8'h00; m_reqq[m] = 8'h00; m_last[m] = 3'd7;
      m_code[m] = 3'd0;  m_valid[m] = 1'b0; m_ovf[m] = 1'b0;
    end else begin
      rise = req & ~m_reqq[m];
      clr  = 8'h00;
      if ((!m_valid[m] || ready) && m_pend[m] != 8'h00) begin
        s = pick(m_pend[m], m_last[m], m);
        m_code[m]  = s;
        m_last[m]  = s;
        clr        = 8'h01 << s;
        m_valid[m] = 1'b1;
      end else if (m_valid[m] && ready) begin
        m_valid[m] = 1'b0;
      end
      m_ovf[m]  = |(rise & m_pend[m] & ~clr);
      m_pend[m] = (m_pend[m] & ~clr) | rise;
      m_reqq[m] = req;
    end
  endtask

  // one clock: model updates on the edge, DUT outputs compared mid-low phase
  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check("fp_valid", {7'd0, u_if_fp.code_valid}, {7'd0, m_valid[0]});
    check("fp_pend",  u_if_fp.pending,            m_pend[0]);
    check("fp_ovf",   {7'd0, u_if_fp.overflow},   {7'd0, m_ovf[0]});
    check("rr_valid", {7'd0, u_if_rr.code_valid}, {7'd0, m_valid[1]});
    check("rr_pend",  u_if_rr.pending,            m_pend[1]);
    check("rr_ovf",   {7'd0, u_if_rr.overflow},   {7'd0, m_ovf[1]});
    if (rst_n && m_valid[0]) check("fp_code", {5'd0, u_if_fp.code}, {5'd0, m_code[0]});
    if (rst_n && m_valid[1]) check("rr_code", {5'd0, u_if_rr.code}, {5'd0, m_code[1]});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 8'hFF;
    ready   = 1'b0;

    // reset held two edges with all requests high
    cyc(); cyc();
    check("rst_code_fp", {5'd0, u_if_fp.code}, 8'd0);
    check("rst_code_rr", {5'd0, u_if_rr.code}, 8'd0);

    // release: all eight captured, then drained in priority order
    rst_n = 1'b1;
    ready = 1'b1;
    cyc();
    check("all_pend_fp", u_if_fp.pending, 8'hFF);
    check("all_pend_rr", u_if_rr.pending, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("drain_fp", {5'd0, u_if_fp.code}, 8'(7 - i));
      check("drain_rr", {5'd0, u_if_rr.code}, 8'(i));
    end
    cyc();
    check("drain_idle_fp", {7'd0, u_if_fp.code_valid}, 8'd0);
    check("drain_idle_rr", {7'd0, u_if_rr.code_valid}, 8'd0);

    // round-robin fairness: issue 6, then 7 and 2 together twice
    req = 8'h00; cyc();
    req = 8'h40; cyc();
    req = 8'h00; cyc();
    check("rr_issue6", {5'd0, u_if_rr.code}, 8'd6);
    cyc();
    for (int r = 0; r < 2; r++) begin
      req = 8'h84; cyc();
      req = 8'h00; cyc();
      check("rr_first7", {5'd0, u_if_rr.code}, 8'd7);
      cyc();
      check("rr_then2", {5'd0, u_if_rr.code}, 8'd2);
      cyc();
      check("rr_idle", {7'd0, u_if_rr.code_valid}, 8'd0);
    end

    // overflow: bit 3 re-pulsed while pending behind a stalled code 5
    ready = 1'b0;
    req = 8'h20; cyc();
    req = 8'h00; cyc();
    check("stall_code5", {5'd0, u_if_fp.code}, 8'd5);
    req = 8'h08; cyc();
    req = 8'h00; cyc();
    req = 8'h08; cyc();
    check("ovf_pulse", {7'd0, u_if_fp.overflow}, 8'd1);
    req = 8'h00; cyc();
    check("ovf_clear", {7'd0, u_if_fp.overflow}, 8'd0);
    check("ovf_pend", u_if_fp.pending, 8'h08);
    ready = 1'b1; cyc();
    check("after5_code3", {5'd0, u_if_fp.code}, 8'd3);
    cyc();
    check("one_code3", {7'd0, u_if_fp.code_valid}, 8'd0);

    // randomized traffic with occasional reset
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) req = req ^ (8'($urandom) & 8'($urandom));
      ready = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
